// File: rtl/permute_pipeline_scheduler_if.sv
// Handshake bundle between the permutation scheduler and its job source, bot stream,
// pipeline issue/return ports and per-top result sink.
interface permute_pipeline_scheduler_if #(
  parameter int MAX_INFLIGHT = 64
);
  localparam int IW = $clog2(MAX_INFLIGHT) + 1;

  logic          job_valid, job_ready;
  logic [127:0]  job_top;
  logic [15:0]   job_bot_count;
  logic          bot_valid, bot_ready;
  logic [127:0]  bot_data;
  logic          pipe_ivalid, pipe_oready, pipe_start_new_top;
  logic [127:0]  pipe_bot;
  logic          pipe_ovalid, pipe_iready;
  logic [63:0]   pipe_result;
  logic          res_valid, res_ready;
  logic [63:0]   res_sum;
  logic [31:0]   res_count;
  logic          res_ecc;
  logic [IW-1:0] inflight;

  modport master (
    input  job_valid, job_top, job_bot_count, bot_valid, bot_data,
           pipe_oready, pipe_ovalid, pipe_result, res_ready,
    output job_ready, bot_ready, pipe_ivalid, pipe_start_new_top, pipe_bot,
           pipe_iready, res_valid, res_sum, res_count, res_ecc, inflight
  );
  modport slave (
    output job_valid, job_top, job_bot_count, bot_valid, bot_data,
           pipe_oready, pipe_ovalid, pipe_result, res_ready,
    input  job_ready, bot_ready, pipe_ivalid, pipe_start_new_top, pipe_bot,
           pipe_iready, res_valid, res_sum, res_count, res_ecc, inflight
  );
endinterface

// File: rtl/permute_pipeline_scheduler.sv
// Issues a marker + bots per top under a credit limit and folds returned bot results per top.
// Optional OCCUPANCY_CAPTURE_EN exposes the marker result as occ_valid/occ_num/occ_den.
module permute_pipeline_scheduler #(
  parameter int MAX_INFLIGHT = 64,
  parameter int MAX_TOPS     = 4
) (
  input  logic clock,
  input  logic rst,
`ifdef OCCUPANCY_CAPTURE_EN
  output logic        occ_valid,
  output logic [31:0] occ_num,
  output logic [31:0] occ_den,
`endif
  permute_pipeline_scheduler_if.master io
);
  localparam int IW = $clog2(MAX_INFLIGHT) + 1;
  localparam int TW = (MAX_TOPS > 1) ? $clog2(MAX_TOPS) : 1;

  typedef enum logic [1:0] {I_IDLE, I_TOP, I_BOTS} iss_e;
  typedef enum logic       {R_MARK, R_BOTS} ret_e;

  iss_e          iss_q, iss_d;
  ret_e          ret_q, ret_d;
  logic [127:0]  top_q, top_d;
  logic [15:0]   rem_q, rem_d, rrem_q, rrem_d;
  logic          job_ready_q, job_ready_d, run_q;
  logic [IW-1:0] infl_q, infl_d;
  logic [15:0]   fifo_q [MAX_TOPS];
  logic [TW-1:0] wr_q, rd_q;
  logic [TW:0]   cnt_q, cnt_d;
  logic          res_valid_q, res_valid_d, ecc_q, ecc_d;
  logic [63:0]   sum_q, sum_d;
  logic [31:0]   pcnt_q, pcnt_d;

  logic         credit_full, issue, ret_fire, push, pop;
  logic         pipe_ivalid, pipe_iready, bot_ready, start_top;
  logic [127:0] pipe_bot;
  logic [15:0]  head_n;

  function automatic logic [TW-1:0] nxt(input logic [TW-1:0] p);
    return (p == TW'(MAX_TOPS - 1)) ? '0 : p + 1'b1;
  endfunction

  assign credit_full = (infl_q == IW'(MAX_INFLIGHT));
  assign issue       = pipe_ivalid && io.pipe_oready;
  assign pipe_iready = run_q && !(res_valid_q && !io.res_ready);
  assign ret_fire    = io.pipe_ovalid && pipe_iready;
  assign pop         = res_valid_q && io.res_ready;
  // A marker accepted during the pop cycle belongs to the entry behind the head.
  assign head_n      = fifo_q[res_valid_q ? nxt(rd_q) : rd_q];

  always_comb begin
    iss_d = iss_q; top_d = top_q; rem_d = rem_q; push = 1'b0;
    pipe_ivalid = 1'b0; start_top = 1'b0; pipe_bot = top_q; bot_ready = 1'b0;
    case (iss_q)
      I_IDLE: if (io.job_valid && job_ready_q) begin
        push = 1'b1; top_d = io.job_top; rem_d = io.job_bot_count; iss_d = I_TOP;
      end
      I_TOP: begin
        pipe_ivalid = !credit_full;
        start_top   = 1'b1;
        if (!credit_full && io.pipe_oready) iss_d = (rem_q == 16'd0) ? I_IDLE : I_BOTS;
      end
      I_BOTS: begin
        pipe_ivalid = io.bot_valid && !credit_full;
        bot_ready   = io.pipe_oready && !credit_full;
        pipe_bot    = io.bot_data;
        if (io.bot_valid && !credit_full && io.pipe_oready) begin
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1) iss_d = I_IDLE;
        end
      end
      default: iss_d = I_IDLE;
    endcase
  end

  assign cnt_d       = cnt_q + (TW+1)'(push) - (TW+1)'(pop);
  assign job_ready_d = (iss_d == I_IDLE) && (cnt_d < (TW+1)'(MAX_TOPS));

  always_comb begin
    infl_d = infl_q;
    if (issue && !ret_fire)      infl_d = infl_q + IW'(1);
    else if (!issue && ret_fire) infl_d = infl_q - IW'(1);
  end

  always_comb begin
    ret_d = ret_q; rrem_d = rrem_q; res_valid_d = res_valid_q;
    sum_d = sum_q; pcnt_d = pcnt_q; ecc_d = ecc_q;
    if (pop) begin
      res_valid_d = 1'b0; sum_d = '0; pcnt_d = '0; ecc_d = 1'b0;
    end
    if (ret_fire) begin
      if (ret_q == R_MARK) begin
        if (head_n == 16'd0) res_valid_d = 1'b1;
        else begin rrem_d = head_n; ret_d = R_BOTS; end
      end else begin
        sum_d  = sum_q + {16'd0, io.pipe_result[47:0]};
        pcnt_d = pcnt_q + {19'd0, io.pipe_result[60:48]};
        ecc_d  = ecc_q | io.pipe_result[63];
        rrem_d = rrem_q - 16'd1;
        if (rrem_q == 16'd1) begin res_valid_d = 1'b1; ret_d = R_MARK; end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      iss_q <= I_IDLE; ret_q <= R_MARK; top_q <= '0; rem_q <= '0; rrem_q <= '0;
      job_ready_q <= 1'b0; run_q <= 1'b0; infl_q <= '0;
      wr_q <= '0; rd_q <= '0; cnt_q <= '0;
      res_valid_q <= 1'b0; sum_q <= '0; pcnt_q <= '0; ecc_q <= 1'b0;
    end else begin
      iss_q <= iss_d; ret_q <= ret_d; top_q <= top_d; rem_q <= rem_d; rrem_q <= rrem_d;
      job_ready_q <= job_ready_d; run_q <= 1'b1; infl_q <= infl_d;
      cnt_q <= cnt_d;
      if (push) wr_q <= nxt(wr_q);
      if (pop)  rd_q <= nxt(rd_q);
      res_valid_q <= res_valid_d; sum_q <= sum_d; pcnt_q <= pcnt_d; ecc_q <= ecc_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_q[wr_q] <= io.job_bot_count;
  end

`ifdef OCCUPANCY_CAPTURE_EN
  logic occ_valid_q;
  logic [31:0] occ_num_q, occ_den_q;
  logic marker_fire;
  assign marker_fire = ret_fire && (ret_q == R_MARK);
  always_ff @(posedge clock) begin
    if (!rst) begin
      occ_valid_q <= 1'b0; occ_num_q <= '0; occ_den_q <= '0;
    end else begin
      occ_valid_q <= marker_fire;
      if (marker_fire) begin
        occ_num_q <= io.pipe_result[63:32];
        occ_den_q <= io.pipe_result[31:0];
      end
    end
  end
  assign occ_valid = occ_valid_q;
  assign occ_num   = occ_num_q;
  assign occ_den   = occ_den_q;
`endif

  assign io.job_ready          = job_ready_q;
  assign io.bot_ready          = bot_ready;
  assign io.pipe_ivalid        = pipe_ivalid;
  assign io.pipe_start_new_top = start_top;
  assign io.pipe_bot           = pipe_bot;
  assign io.pipe_iready        = pipe_iready;
  assign io.res_valid          = res_valid_q;
  assign io.res_sum            = sum_q;
  assign io.res_count          = pcnt_q;
  assign io.res_ecc            = ecc_q;
  assign io.inflight           = infl_q;
endmodule

// File: tb/tb_permute_pipeline_scheduler.sv
// Randomized bench: queue-based model of job/bot/pipeline traffic with a per-cycle scoreboard.
module tb_permute_pipeline_scheduler;
  localparam int MI = 4, MT = 4;

  logic clock = 1'b0, rst = 1'b0;
  always #5 clock = ~clock;

  permute_pipeline_scheduler_if #(.MAX_INFLIGHT(MI)) io ();
  permute_pipeline_scheduler #(.MAX_INFLIGHT(MI), .MAX_TOPS(MT)) dut (.clock(clock), .rst(rst), .io(io));

  typedef struct packed { logic mark; logic [127:0] data; } item_t;
  typedef struct packed { logic [63:0] sum; logic [31:0] cnt; logic ecc; } res_t;

  item_t        exp_items[$];
  item_t        pipe_q[$];
  logic [127:0] job_top_q[$];
  int           job_n_q[$];
  logic [127:0] bot_src[$];
  logic [63:0]  bot_res[$];
  logic [63:0]  forced[$];
  res_t         exp_res[$];
  logic         popped_ecc[$];

  int n_vec = 0, n_err = 0;
  int model_infl = 0, outstanding = 0, issued = 0, ret_budget = -1;
  int p_jobv = 100, p_botv = 100, p_oready = 100, p_ovalid = 100, p_resready = 100;
  logic job_f = 0, bot_f = 0, ret_f = 0;
  logic prev_iv_hold = 0, prev_res_hold = 0;
  item_t prev_item;
  res_t prev_res, last_res;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] rv(input int n, input int s, input logic e);
    return {e, 2'b00, 13'(n), 48'(s)};
  endfunction

  task automatic add_job(input int n);
    logic [127:0] top, b;
    logic [63:0] v, s;
    logic [31:0] c;
    logic e;
    top = {$urandom, $urandom, $urandom, $urandom};
    job_top_q.push_back(top); job_n_q.push_back(n);
    exp_items.push_back('{mark: 1'b1, data: top});
    s = '0; c = '0; e = 1'b0;
    for (int k = 0; k < n; k++) begin
      b = {$urandom, $urandom, $urandom, $urandom};
      bot_src.push_back(b);
      exp_items.push_back('{mark: 1'b0, data: b});
      if (forced.size() > 0) v = forced.pop_front();
      else begin v = {$urandom, $urandom}; v[63] = ($urandom_range(15) == 0); end
      bot_res.push_back(v);
      s = s + {16'd0, v[47:0]}; c = c + {19'd0, v[60:48]}; e = e | v[63];
    end
    exp_res.push_back('{sum: s, cnt: c, ecc: e});
  endtask

  task automatic step();
    logic iss, res_f;
    item_t it, got;
    res_t cur, e;
    @(negedge clock);
    if (job_f) io.job_valid = 1'b0;
    if (bot_f) io.bot_valid = 1'b0;
    if (ret_f) io.pipe_ovalid = 1'b0;
    if (!io.job_valid && job_top_q.size() > 0 && $urandom_range(99) < p_jobv) begin
      io.job_valid = 1'b1; io.job_top = job_top_q[0]; io.job_bot_count = 16'(job_n_q[0]);
    end
    if (!io.bot_valid && bot_src.size() > 0 && $urandom_range(99) < p_botv) begin
      io.bot_valid = 1'b1; io.bot_data = bot_src[0];
    end
    if (!io.pipe_ovalid && pipe_q.size() > 0 && ret_budget != 0 && $urandom_range(99) < p_ovalid) begin
      io.pipe_ovalid = 1'b1;
      io.pipe_result = pipe_q[0].mark ? {$urandom, $urandom} : bot_res[0];
      if (ret_budget > 0) ret_budget--;
    end
    io.pipe_oready = ($urandom_range(99) < p_oready);
    io.res_ready   = ($urandom_range(99) < p_resready);
    #1;
    job_f = io.job_valid && io.job_ready;
    bot_f = io.bot_valid && io.bot_ready;
    iss   = io.pipe_ivalid && io.pipe_oready;
    ret_f = io.pipe_ovalid && io.pipe_iready;
    res_f = io.res_valid && io.res_ready;
    got   = '{mark: io.pipe_start_new_top, data: io.pipe_bot};
    cur   = '{sum: io.res_sum, cnt: io.res_count, ecc: io.res_ecc};

    chk("inflight", 256'(io.inflight), 256'(model_infl));
    if (model_infl == MI) chk("credit_gate", 256'({io.pipe_ivalid, io.bot_ready}), 256'(0));
    if (outstanding == MT) chk("job_ready_full", 256'(io.job_ready), 256'(0));
    if (prev_iv_hold) chk("issue_hold", 256'({io.pipe_ivalid, got}), 256'({1'b1, prev_item}));
    if (prev_res_hold) chk("res_hold", 256'({io.res_valid, cur}), 256'({1'b1, prev_res}));
    if (bot_f) chk("bot_issue", 256'(iss), 256'(1));

    if (iss) begin
      if (exp_items.size() == 0) chk("issue_unexpected", 256'(got), 256'(0));
      else begin
        it = exp_items.pop_front();
        chk("issue_item", 256'(got), 256'(it));
        pipe_q.push_back(it);
      end
      issued++;
    end
    if (job_f) begin void'(job_top_q.pop_front()); void'(job_n_q.pop_front()); outstanding++; end
    if (bot_f) void'(bot_src.pop_front());
    if (ret_f && pipe_q.size() > 0) begin
      it = pipe_q.pop_front();
      if (!it.mark) void'(bot_res.pop_front());
    end
    if (res_f) begin
      if (exp_res.size() == 0) chk("res_unexpected", 256'(cur), 256'(0));
      else begin
        e = exp_res.pop_front();
        chk("result", 256'(cur), 256'(e));
      end
      last_res = cur; popped_ecc.push_back(cur.ecc); outstanding--;
    end
    model_infl    = model_infl + int'(iss) - int'(ret_f);
    prev_iv_hold  = io.pipe_ivalid && !iss;  prev_item = got;
    prev_res_hold = io.res_valid && !res_f;  prev_res  = cur;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    io.job_valid = 1'b0; io.bot_valid = 1'b0; io.pipe_ovalid = 1'b0;
    io.pipe_oready = 1'b1; io.res_ready = 1'b1;
    job_f = 0; bot_f = 0; ret_f = 0;
    repeat (2) @(posedge clock);
    @(negedge clock); #1;
    chk("rst_ctrl", 256'({io.job_ready, io.bot_ready, io.pipe_ivalid, io.pipe_iready, io.res_valid, io.res_ecc}), 256'(0));
    chk("rst_sum", 256'(io.res_sum), 256'(0));
    chk("rst_count", 256'(io.res_count), 256'(0));
    chk("rst_inflight", 256'(io.inflight), 256'(0));
    exp_items.delete(); pipe_q.delete(); job_top_q.delete(); job_n_q.delete();
    bot_src.delete(); bot_res.delete(); exp_res.delete(); forced.delete();
    model_infl = 0; outstanding = 0; issued = 0;
    prev_iv_hold = 0; prev_res_hold = 0;
    rst = 1'b1;
  endtask

  task automatic drain(input int bound);
    int k = 0;
    while (exp_res.size() > 0 && k < bound) begin step(); k++; end
    chk("drain_left", 256'(exp_res.size()), 256'(0));
  endtask

  initial begin
    int k;
    io.job_valid = 0; io.job_top = '0; io.job_bot_count = '0;
    io.bot_valid = 0; io.bot_data = '0; io.pipe_oready = 0;
    io.pipe_ovalid = 0; io.pipe_result = '0; io.res_ready = 0;
    do_reset();

    // three bots: sums 5,7,9 and counts 1,2,3
    forced.push_back(rv(1, 5, 0)); forced.push_back(rv(2, 7, 0)); forced.push_back(rv(3, 9, 0));
    add_job(3); drain(200);
    chk("lit_sum21", 256'(last_res.sum), 256'(21));
    chk("lit_cnt6", 256'(last_res.cnt), 256'(6));
    chk("lit_ecc0", 256'(last_res.ecc), 256'(0));

    add_job(0); drain(200);
    chk("lit_zero_sum", 256'(last_res.sum), 256'(0));
    chk("lit_zero_cnt", 256'(last_res.cnt), 256'(0));

    // credit limit with returns held off
    ret_budget = 0; issued = 0;
    add_job(6);
    repeat (10) step();
    chk("credit_issued4", 256'(issued), 256'(4));
    chk("credit_infl4", 256'(io.inflight), 256'(MI));
    chk("credit_ivalid0", 256'(io.pipe_ivalid), 256'(0));
    ret_budget = 1;
    repeat (10) step();
    chk("credit_issued5", 256'(issued), 256'(5));
    ret_budget = -1; drain(300);

    // five zero-bot jobs against a four-deep tracking FIFO
    ret_budget = 0;
    for (int j = 0; j < 5; j++) add_job(0);
    repeat (20) step();
    chk("fifo_outstanding4", 256'(outstanding), 256'(4));
    chk("fifo_job_ready0", 256'(io.job_ready), 256'(0));
    ret_budget = -1; drain(300);

    // result sink stalled for 20 cycles, first top carries an ecc error
    p_resready = 0; popped_ecc.delete();
    forced.push_back(rv(0, 100, 1)); forced.push_back(rv(4, 50, 0)); forced.push_back(rv(1, 8, 0));
    add_job(2); add_job(1);
    repeat (20) step();
    chk("stall_res_valid", 256'(io.res_valid), 256'(1));
    chk("stall_iready0", 256'(io.pipe_iready), 256'(0));
    p_resready = 100; drain(300);
    chk("ecc_pops", 256'(popped_ecc.size()), 256'(2));
    if (popped_ecc.size() >= 2) begin
      chk("ecc_first1", 256'(popped_ecc[0]), 256'(1));
      chk("ecc_second0", 256'(popped_ecc[1]), 256'(0));
    end

    // reset in the middle of a bot stream
    ret_budget = 0; issued = 0;
    add_job(10);
    k = 0;
    while (issued < 3 && k < 50) begin step(); k++; end
    chk("midbots_reached", 256'(issued >= 3), 256'(1));
    do_reset();
    ret_budget = -1;
    forced.push_back(rv(1, 5, 0)); forced.push_back(rv(2, 7, 0)); forced.push_back(rv(3, 9, 0));
    add_job(3); drain(200);
    chk("post_rst_sum21", 256'(last_res.sum), 256'(21));

    for (int b = 0; b < 4; b++) begin
      p_jobv = $urandom_range(100, 30); p_botv = $urandom_range(100, 30);
      p_oready = $urandom_range(100, 30); p_ovalid = $urandom_range(100, 30);
      p_resready = $urandom_range(100, 20);
      for (int j = 0; j < 10; j++) add_job($urandom_range(6));
      drain(5000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
